pipe_latch_ctrl: RTL

- Central sequencer for the MIPS pipeline registers: the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Drives every latch enable and the two bubble/flush controls.
- Run/step/halt state machine serves the debug unit; load-use stall and taken-branch flush requests come from the hazard unit.
- Counts executed (advanced) cycles for the debug unit.

---
 rtl/pipe_latch_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pipe_latch_ctrl.sv
// Pipeline latch sequencer: run/step/halt FSM, load-use stall and branch flush control, cycle counter.
// Outputs are combinational from state and inputs; define PIPE_WATCHDOG_EN to add the stall watchdog.
module pipe_latch_ctrl #(
    parameter int CNT_W     = 16,
    parameter int STALL_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_run,
    input  logic             i_step,
    input  logic             i_halt,
    input  logic             i_halt_instr,
    input  logic             i_load_use,
    input  logic             i_branch_taken,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_idex_en,
    output logic             o_exmem_en,
    output logic             o_memwb_en,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic             o_done,
    output logic             o_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_adv;
    logic             w_wd_trip;

    // A HALT opcode in MEM/WB freezes every latch in the cycle it is seen.
    assign w_adv = rst && (r_state == S_RUN || r_state == S_STEP) && !i_halt_instr;

`ifdef PIPE_WATCHDOG_EN
    localparam int STALL_W = $clog2(STALL_MAX + 1);

    logic [STALL_W-1:0] r_stall;
    logic               r_err;
    logic               w_stall_cyc;

    assign w_stall_cyc = w_adv && i_load_use && !i_branch_taken;
    assign w_wd_trip   = w_stall_cyc && (r_stall == STALL_W'(STALL_MAX - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_stall_cyc && !w_wd_trip)
                r_stall <= r_stall + 1'b1;
            else
                r_stall <= '0;
            if (w_wd_trip)
                r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign w_wd_trip = 1'b0;
    assign o_err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_adv && r_cnt != {CNT_W{1'b1}})
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_halt)
                    w_next = S_IDLE;
                else if (i_run)
                    w_next = S_RUN;
                else if (i_step)
                    w_next = S_STEP;
            end
            S_RUN: begin
                if (i_halt_instr || w_wd_trip)
                    w_next = S_DONE;
                else if (i_halt)
                    w_next = S_IDLE;
            end
            S_STEP: begin
                if (i_halt_instr || w_wd_trip)
                    w_next = S_DONE;
                else
                    w_next = S_IDLE;
            end
            default: w_next = S_DONE;
        endcase
    end

    always_comb begin
        o_pc_en      = 1'b0;
        o_ifid_en    = 1'b0;
        o_idex_en    = 1'b0;
        o_exmem_en   = 1'b0;
        o_memwb_en   = 1'b0;
        o_ifid_flush = 1'b0;
        o_idex_flush = 1'b0;
        if (w_adv) begin
            o_pc_en    = 1'b1;
            o_ifid_en  = 1'b1;
            o_idex_en  = 1'b1;
            o_exmem_en = 1'b1;
            o_memwb_en = 1'b1;
            // A taken branch squashes the stalled instruction, so the stall is moot.
            if (i_branch_taken) begin
                o_ifid_flush = 1'b1;
                o_idex_flush = 1'b1;
            end else if (i_load_use) begin
                o_pc_en      = 1'b0;
                o_ifid_en    = 1'b0;
                o_idex_flush = 1'b1;
            end
        end
    end

    assign o_state     = r_state;
    assign o_cycle_cnt = r_cnt;
    assign o_done      = rst && (r_state == S_DONE);

endmodule
